// File: rtl/mac_window_acc.sv
// Sequential window multiply-accumulate: sums KxK window dot products over a
// programmable number of beats, then rounds, activates and saturates one result.
`timescale 1ns/1ps
module mac_window_acc #(
  parameter int DATA_SIZE     = 16,
  parameter int FRAC_BITS     = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_LENGTH = 3,
  parameter int ACC_WIDTH     = 56
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic [15:0]                                     cfg_beats,
  input  logic [1:0]                                      cfg_act,
  input  logic [DATA_SIZE-1:0]                            bias,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] map_in,
  input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] kernel_in,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DATA_SIZE-1:0]                            mac_out,
  output logic                                            sat_flag,
  output logic                                            busy
);

  localparam int N      = KERNEL_WIDTH * KERNEL_LENGTH;
  localparam int PSUM_W = 2 * DATA_SIZE + $clog2(N);

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX    = (ACC_WIDTH'(1) << (DATA_SIZE - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN    = -(ACC_WIDTH'(1) << (DATA_SIZE - 1));
  localparam logic signed [ACC_WIDTH-1:0] ROUND_TERM = (ACC_WIDTH'(1) << FRAC_BITS) >> 1;
  localparam logic signed [ACC_WIDTH-1:0] SIX        = ACC_WIDTH'(6) << FRAC_BITS;
  localparam logic signed [ACC_WIDTH-1:0] RELU6_CAP  = (SIX > OUT_MAX) ? OUT_MAX : SIX;
  localparam logic [DATA_SIZE-1:0]        MAX_WORD   = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0]        MIN_WORD   = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, ROUND, OUT} state_t;

  state_t state, state_next;

  logic [15:0]                  beats_cfg, beat_cnt;
  logic [1:0]                   act_cfg;
  logic signed [ACC_WIDTH-1:0]  acc, act_val, bias_ext, rounded, act_comb;
  logic signed [PSUM_W-1:0]     psum, psum_comb, m_ext, k_ext;
  logic                         psum_v, round_phase, accept, last_beat;
  logic                         sat_hi, sat_lo;

  assign in_ready  = (state == ACC);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign last_beat = accept && (beat_cnt == beats_cfg - 16'd1);
  assign bias_ext  = ACC_WIDTH'($signed(bias)) << FRAC_BITS;

  // Element 0 sits in the MSBs of both packed windows.
  always_comb begin
    psum_comb = '0;
    m_ext     = '0;
    k_ext     = '0;
    for (int i = 0; i < N; i++) begin
      m_ext     = PSUM_W'($signed(map_in[(N-i)*DATA_SIZE-1 -: DATA_SIZE]));
      k_ext     = PSUM_W'($signed(kernel_in[(N-i)*DATA_SIZE-1 -: DATA_SIZE]));
      psum_comb = psum_comb + m_ext * k_ext;
    end
  end

  always_comb begin
    rounded  = (acc + ROUND_TERM) >>> FRAC_BITS;
    act_comb = rounded;
    case (act_cfg)
      2'd1: act_comb = (rounded < 0) ? '0 : rounded;
      2'd2: act_comb = (rounded < 0) ? '0 : ((rounded > RELU6_CAP) ? RELU6_CAP : rounded);
      default: act_comb = rounded;
    endcase
    sat_hi = (act_val > OUT_MAX);
    sat_lo = (act_val < OUT_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ROUND spans two cycles: activation is registered before the final clamp.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACC;
      ACC:     if (last_beat) state_next = DRAIN;
      DRAIN:   state_next = ROUND;
      ROUND:   if (round_phase) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_cfg   <= '0;
      act_cfg     <= '0;
      beat_cnt    <= '0;
      acc         <= '0;
      psum        <= '0;
      psum_v      <= 1'b0;
      act_val     <= '0;
      round_phase <= 1'b0;
      mac_out     <= '0;
      sat_flag    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        beats_cfg <= (cfg_beats == 16'd0) ? 16'd1 : cfg_beats;
        act_cfg   <= cfg_act;
        acc       <= bias_ext;
        beat_cnt  <= '0;
        psum      <= '0;
        psum_v    <= 1'b0;
      end else begin
        psum_v <= accept;
        if (accept) begin
          psum     <= psum_comb;
          beat_cnt <= beat_cnt + 16'd1;
        end
        if (psum_v) acc <= acc + ACC_WIDTH'(psum);
      end

      round_phase <= (state == ROUND) ? ~round_phase : 1'b0;
      if (state == ROUND && !round_phase) act_val <= act_comb;
      if (state == ROUND && round_phase) begin
        mac_out   <= sat_hi ? MAX_WORD : (sat_lo ? MIN_WORD : act_val[DATA_SIZE-1:0]);
        sat_flag  <= sat_hi | sat_lo;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_window_acc.sv
// Directed bench for mac_window_acc: an arithmetic reference model checked every
// cycle the result is valid, plus hand-computed literal results for each scenario.
`timescale 1ns/1ps
module tb_mac_window_acc;

  localparam int D = 16;
  localparam int N = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic [15:0]      cfg_beats = '0;
  logic [1:0]       cfg_act = '0;
  logic [D-1:0]     bias = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [D*N-1:0]   map_in = '0;
  logic [D*N-1:0]   kernel_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [D-1:0]     mac_out;
  logic             sat_flag;
  logic             busy;

  int               map_w [N];
  int               ker_w [N];
  logic signed [D-1:0] exp_mac = '0;
  logic             exp_sat = 1'b0;
  int               vec_count = 0;
  int               miscompares = 0;
  int               lat;
  logic [D-1:0]     held;

  mac_window_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_beats(cfg_beats),
    .cfg_act(cfg_act), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .map_in(map_in), .kernel_in(kernel_in), .out_valid(out_valid),
    .out_ready(out_ready), .mac_out(mac_out), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint got, input longint want);
    vec_count++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Whenever a result is presented it must match the reference model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      vec_count++;
      if (mac_out !== exp_mac || sat_flag !== exp_sat) begin
        miscompares++;
        $display("[TB] FAIL model_compare: got mac_out=%0d sat=%0b, want mac_out=%0d sat=%0b",
                 $signed(mac_out), sat_flag, exp_mac, exp_sat);
      end
    end
  end

  task automatic setWindow(input int mv, input int kv);
    for (int i = 0; i < N; i++) begin
      map_w[i] = mv;
      ker_w[i] = kv;
    end
  endtask

  task automatic computeModel(input int beats, input logic [1:0] act, input int bias_v);
    longint dot, total, r;
    int     eff;
    eff = (beats == 0) ? 1 : beats;
    dot = 0;
    for (int i = 0; i < N; i++) dot += longint'(map_w[i]) * longint'(ker_w[i]);
    total = longint'(bias_v) * 256 + dot * eff;
    r = total + 128;
    r = (r >= 0) ? (r / 256) : -((-r + 255) / 256);
    if (act == 2'd1 || act == 2'd2) r = (r < 0) ? 0 : r;
    if (act == 2'd2 && r > 1536) r = 1536;
    exp_sat = (r > 32767) || (r < -32768);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    exp_mac = D'(r);
  endtask

  // Runs one result: start, feed beats (optionally with the 1,0,0,1,0,1 valid
  // pattern), and return the edge count from last acceptance to out_valid.
  task automatic applyStimulus(input int beats, input logic [1:0] act, input int bias_v,
                               input bit gaps, output int latency);
    int eff, accepted, c;
    bit hit;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eff = (beats == 0) ? 1 : beats;
    computeModel(beats, act, bias_v);
    for (int i = 0; i < N; i++) begin
      map_in[(N-i)*D-1 -: D]    = D'(map_w[i]);
      kernel_in[(N-i)*D-1 -: D] = D'(ker_w[i]);
    end
    start     = 1'b1;
    cfg_beats = 16'(beats);
    cfg_act   = act;
    bias      = D'(bias_v);
    @(negedge clk);
    start     = 1'b0;
    cfg_beats = 16'd7;
    cfg_act   = 2'd3;
    bias      = 16'h7fff;
    accepted  = 0;
    c         = 0;
    while (accepted < eff && c < 200) begin
      in_valid = gaps ? pat[c % 6] : 1'b1;
      hit      = in_valid && in_ready;
      @(negedge clk);
      if (hit) accepted++;
      c++;
    end
    checkOutput("beats_accepted", accepted, eff);
    checkOutput("in_ready_after_last", in_ready, 0);
    latency = 0;
    while (!out_valid && latency < 20) begin
      in_valid = gaps ? pat[c % 6] : 1'b1;
      @(negedge clk);
      latency++;
      c++;
    end
    in_valid = 1'b0;
    checkOutput("latency", latency, 3);
  endtask

  task automatic finishResult(input string name, input int lit_mac, input int lit_sat);
    checkOutput({name, "_mac"}, longint'($signed(mac_out)), lit_mac);
    checkOutput({name, "_sat"}, sat_flag, lit_sat);
    @(negedge clk);
    checkOutput({name, "_valid_drop"}, out_valid, 0);
    checkOutput({name, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    $display("[TB] mac_window_acc directed run");
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mac_out", mac_out, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    setWindow(256, 128);
    applyStimulus(1, 2'd0, 64, 1'b0, lat);
    finishResult("basic", 1216, 0);

    setWindow(256, 256);
    applyStimulus(3, 2'd0, 0, 1'b1, lat);
    finishResult("three_beats", 6912, 0);
    applyStimulus(3, 2'd2, 0, 1'b1, lat);
    finishResult("three_beats_relu6", 1536, 0);

    setWindow(256, -256);
    applyStimulus(1, 2'd0, 0, 1'b0, lat);
    finishResult("negative", -2304, 0);
    applyStimulus(1, 2'd1, 0, 1'b0, lat);
    finishResult("negative_relu", 0, 0);

    setWindow(1, 128);
    applyStimulus(1, 2'd0, 0, 1'b0, lat);
    finishResult("round_half_up", 5, 0);
    setWindow(1, -128);
    applyStimulus(1, 2'd3, 0, 1'b0, lat);
    finishResult("round_neg_half", -4, 0);

    setWindow(32767, 32767);
    applyStimulus(1, 2'd0, 0, 1'b0, lat);
    finishResult("sat_pos", 32767, 1);
    applyStimulus(1, 2'd2, 0, 1'b0, lat);
    finishResult("relu6_no_sat", 1536, 0);
    setWindow(32767, -32768);
    applyStimulus(1, 2'd0, 0, 1'b0, lat);
    finishResult("sat_neg", -32768, 1);
    applyStimulus(1, 2'd1, 0, 1'b0, lat);
    finishResult("relu_no_sat", 0, 0);

    setWindow(256, 128);
    applyStimulus(0, 2'd0, 64, 1'b0, lat);
    finishResult("zero_beats", 1216, 0);

    for (int i = 0; i < N; i++) begin
      map_w[i] = (i + 1) * 256;
      ker_w[i] = i * 16;
    end
    applyStimulus(1, 2'd0, -3, 1'b0, lat);
    finishResult("element_order", 3837, 0);

    setWindow(256, 128);
    out_ready = 1'b0;
    applyStimulus(1, 2'd0, 64, 1'b0, lat);
    held = mac_out;
    for (int i = 0; i < 5; i++) begin
      start    = ~start;
      in_valid = ~in_valid;
      @(negedge clk);
      checkOutput("hold_mac", mac_out, held);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_valid", out_valid, 1);
    end
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_release_valid", out_valid, 0);
    checkOutput("hold_release_busy", busy, 0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("start_ignored_busy", busy, 0);

    setWindow(256, 256);
    start     = 1'b1;
    cfg_beats = 16'd3;
    cfg_act   = 2'd0;
    bias      = '0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_mac_out", mac_out, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_sat", sat_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    setWindow(256, 128);
    applyStimulus(1, 2'd0, 64, 1'b0, lat);
    finishResult("after_reset", 1216, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
